// File: rtl/ttl_pkg.sv
// Shared package for the TTL universal-register family.
// Mode encodings are common to the 74194, 74195 and 74299 parts.
package ttl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/ttl_74194_if.sv
// Signal bundle for the 74194 register: mode, serial/parallel data, Q.
// Enable_bar exists only when TTL_74194_CLOCK_ENABLE_EN is defined.
interface ttl_74194_if
  import ttl_pkg::*;
#(
  parameter int WIDTH = 4
);
`ifdef TTL_74194_CLOCK_ENABLE_EN
  logic             Enable_bar;
`endif
  mode_t            S;
  logic             DSR;
  logic             DSL;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;

  modport master (
`ifdef TTL_74194_CLOCK_ENABLE_EN
    output Enable_bar,
`endif
    output S,
    output DSR,
    output DSL,
    output D,
    input  Q
  );

  modport slave (
`ifdef TTL_74194_CLOCK_ENABLE_EN
    input  Enable_bar,
`endif
    input  S,
    input  DSR,
    input  DSL,
    input  D,
    output Q
  );

endinterface

// File: rtl/ttl_74194_cell.sv
// One bit of the 74194: 4:1 next-state select plus
// an async-clear flop. No output delay here.
module ttl_74194_cell
  import ttl_pkg::*;
(
  input  logic  clk,
  input  logic  clr_n,
  input  mode_t mode,
  input  logic  hold,
  input  logic  left,
  input  logic  right,
  input  logic  par,
  output logic  q
);

  logic nxt;

  // Per-edge mode decode; no mode history is kept.
  always_comb begin
    nxt = hold;
    case (mode)
      MODE_HOLD: nxt = hold;
      MODE_SHR:  nxt = left;
      MODE_SHL:  nxt = right;
      MODE_LOAD: nxt = par;
      default:   nxt = hold;
    endcase
  end

  // State flop; clear wins over any clock edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q <= 1'b0;
    else        q <= nxt;
  end

endmodule

// File: rtl/ttl_74194.sv
// 74194 4-bit bidirectional universal shift register (WIDTH bits).
// Optional TTL_74194_CLOCK_ENABLE_EN adds Enable_bar (high = hold).
module ttl_74194
  import ttl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
`ifdef TTL_74194_CLOCK_ENABLE_EN
  input  logic             Enable_bar,
`endif
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH+1:0] ext;
  mode_t            mode;

  // Serial inputs sit at the ends of the chain:
  // bit i takes ext[i] on shift right, ext[i+2] on shift left.
  assign ext = {DSL, q_r, DSR};

`ifdef TTL_74194_CLOCK_ENABLE_EN
  assign mode = Enable_bar ? MODE_HOLD : S;
`else
  assign mode = S;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ttl_74194_cell u_cell (
      .clk   (Clk),
      .clr_n (Clear_bar),
      .mode  (mode),
      .hold  (q_r[i]),
      .left  (ext[i]),
      .right (ext[i+2]),
      .par   (D[i]),
      .q     (q_r[i])
    );
  end

  assign #(DELAY_RISE, DELAY_FALL) Q = q_r;

endmodule

// File: doc/ttl_74194.md
TTL_74194 -- requirements
Module: ttl_74194

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 4: register width, >= 1.
- DELAY_RISE, default 0: output rise delay.
- DELAY_FALL, default 0: output fall delay.

REQ-002 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- Clk, input, 1: single clock, rising-edge active.
- Clear_bar, input, 1: reset, asynchronous, active-low.
- S, input, 2: mode select.
- DSR, input, 1: shift-right serial input.
- DSL, input, 1: shift-left serial input.
- D, input, WIDTH: parallel load data, typically fed from ttl_74157 Y.
- Q, output, WIDTH: register state; Q[0] = QA.

REQ-003 Q SHALL be driven through an assign with #(DELAY_RISE, DELAY_FALL) from an internal state register.

Function
REQ-004 S SHALL be sampled only on the rising edge of Clk; changes between edges SHALL have no effect on Q.
REQ-005 S = 2'b00 (hold): Q SHALL be unchanged.
REQ-006 S = 2'b01 (shift right): Q[0] <= DSR and Q[i] <= Q[i-1] for i = 1..WIDTH-1; the old Q[WIDTH-1] SHALL be discarded.
REQ-007 S = 2'b10 (shift left): Q[WIDTH-1] <= DSL and Q[i] <= Q[i+1] for i = 0..WIDTH-2; the old Q[0] SHALL be discarded.
REQ-008 S = 2'b11 (parallel load): Q <= D, with latency one edge.
REQ-009 With WIDTH = 1, shift right SHALL load DSR and shift left SHALL load DSL.
REQ-010 S or D containing X/Z at an edge SHALL NOT be specially handled; simulation propagation applies.
REQ-011 The mode set is a stateless per-edge decode; no mode history SHALL be retained between edges.

Reset
REQ-012 Clear_bar low SHALL force the state to all zeros immediately, independent of Clk.
REQ-013 While Clear_bar is low, clock edges SHALL be ignored in every mode.
REQ-014 Reset asserted mid-operation (during any shift or load sequence) SHALL discard all state; no partial shift SHALL survive.
REQ-015 The first rising Clk edge with Clear_bar high SHALL execute the mode selected by S normally.
REQ-016 The reset value of Q is 0 (all WIDTH bits), appearing after DELAY_FALL.

Configuration
REQ-017 Macro TTL_74194_CLOCK_ENABLE_EN SHALL add an input port Enable_bar (1 bit) placed after Clear_bar.
REQ-018 With the macro defined:
- Enable_bar high at a rising edge SHALL force hold regardless of S.
- Enable_bar low SHALL give the behaviour of REQ-005..REQ-008.
- Clear_bar SHALL override Enable_bar.
REQ-019 Without the macro, the Enable_bar port SHALL NOT exist and behaviour SHALL be exactly REQ-004..REQ-016.

Structure
REQ-020 The mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD SHALL be localparam constants in the shared package ttl_pkg, reused by other universal-register parts (74195, 74299).
REQ-021 One sub-module is natural and SHALL be used: ttl_74194_cell, a one-bit 4:1 next-state select plus async-clear flop. Its inputs are hold, left neighbour, right neighbour and parallel bit. The top instantiates WIDTH cells in a generate loop, with DSR/DSL at the ends.
REQ-022 The output delay SHALL be applied only once, at the top level, not inside the cells.

Verification
REQ-023 Clear_bar=0 at t=0, then released; D=4'b1010 with S=11, one edge -> Q=4'b0000 while cleared, then Q=4'b1010 after the edge.
REQ-024 From Q=4'b0001, S=01, DSR=1 for 3 edges -> Q=4'b0011, 4'b0111, 4'b1111 (Q[0] fills first).
REQ-025 From Q=4'b1000, S=10, DSL=0 for 4 edges -> Q=4'b0100, 4'b0010, 4'b0001, 4'b0000.
REQ-026 Q=4'b0110 with S=00 and D toggling for 5 edges -> Q stays 4'b0110. Then Clear_bar pulsed low between edges mid-shift -> Q=0 at once, and the next edge with S=11, D=4'b1111 -> Q=4'b1111.
REQ-027 S toggled 01->11->01 between edges with no rising edge -> Q unchanged.
REQ-028 With TTL_74194_CLOCK_ENABLE_EN defined: Enable_bar=1, S=11, D=4'b0101, 2 edges -> Q unchanged. Then Enable_bar=0, one edge -> Q=4'b0101.
